// File: rtl/referee_rr_4_pkg.sv
// Shared definitions for the four-channel round-robin referee and its picker.
package referee_rr_4_pkg;
  localparam int NUM_VC         = 4;
  localparam int DEFAULT_DATA_W = 12;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1
  } state_e;
endpackage

// File: rtl/referee_rr_4_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping mod 4.
module rr_pick_4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_id,
  output logic       any
);
  logic [1:0] idx;

  always_comb begin
    gnt_id = 2'd0;
    idx    = 2'd0;
    any    = |req;
    // Scan farthest-first so the nearest requester after 'last' wins.
    for (int k = 3; k >= 0; k--) begin
      idx = last + 2'(k + 1);
      if (req[idx]) gnt_id = idx;
    end
  end
endmodule

// File: rtl/referee_rr_4.sv
// Drains four VC source FIFOs into one destination FIFO with bounded
// round-robin bursts; one bubble cycle in IDLE per grant, 1-cycle data latency.
module referee_rr_4
  import referee_rr_4_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              empty_3,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic              almost_full,
  output logic              pop_0,
  output logic              pop_1,
  output logic              pop_2,
  output logic              pop_3,
  output logic              push,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        grant_id,
  output logic              busy
);
  if (BURST < 1 || BURST > 15) begin : g_bad_burst
    $error("referee_rr_4: BURST must be in 1..15");
  end

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        last_q, last_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_q, push_d;
  logic [1:0]        pgid_q, pgid_d;

  logic [3:0]        empty_v;
  logic [3:0]        pop_v;
  logic [1:0]        pick_id;
  logic              pick_any;
  logic [DATA_W-1:0] din [NUM_VC];

  assign empty_v = {empty_3, empty_2, empty_1, empty_0};
  assign din[0]  = data_in_0;
  assign din[1]  = data_in_1;
  assign din[2]  = data_in_2;
  assign din[3]  = data_in_3;

  rr_pick_4 u_pick (
    .req    (~empty_v),
    .last   (last_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    pop_v   = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (!almost_full && pick_any) begin
          grant_d = pick_id;
          count_d = '0;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        // A drained source ends the grant even while the destination stalls.
        if (empty_v[grant_q]) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end else if (!almost_full) begin
          pop_v[grant_q] = 1'b1;
          if (count_q == BURST_LAST) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    push_d = |pop_v;
    pgid_d = grant_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'd3;
      count_q <= '0;
      push_q  <= 1'b0;
      pgid_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
      push_q  <= push_d;
      pgid_q  <= pgid_d;
    end
  end

  assign {pop_3, pop_2, pop_1, pop_0} = pop_v;
  assign push     = push_q;
  assign data_out = push_q ? din[pgid_q] : '0;
  assign grant_id = grant_q;
  assign busy     = (state_q == ST_SERVE);
endmodule

// File: tb/tb_referee_rr_4.sv
// Randomized scoreboard bench for referee_rr_4 with source FIFO models and a
// burst-level round-robin reference.
module tb_referee_rr_4;
  localparam int DATA_W = 12;
  localparam int BURST  = 4;
  localparam int W      = DATA_W + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              empty_v [4];
  logic [DATA_W-1:0] din [4];
  logic              almost_full;
  logic              pop_0, pop_1, pop_2, pop_3;
  logic              push;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        grant_id;
  logic              busy;
  logic [3:0]        pops;

  logic [DATA_W-1:0] srcq [4][$];
  logic [W-1:0]      exp_q[$];
  logic [3:0]        p_s;
  int                checks = 0;
  int                errors = 0;
  int                af_mode = 0;
  int                model_last = 3;

  assign pops = {pop_3, pop_2, pop_1, pop_0};

  referee_rr_4 #(.DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk         (clk),
    .reset       (reset),
    .empty_0     (empty_v[0]),
    .empty_1     (empty_v[1]),
    .empty_2     (empty_v[2]),
    .empty_3     (empty_v[3]),
    .data_in_0   (din[0]),
    .data_in_1   (din[1]),
    .data_in_2   (din[2]),
    .data_in_3   (din[3]),
    .almost_full (almost_full),
    .pop_0       (pop_0),
    .pop_1       (pop_1),
    .pop_2       (pop_2),
    .pop_3       (pop_3),
    .push        (push),
    .data_out    (data_out),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  // clock / reset-independent watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic void upd_empty();
    for (int i = 0; i < 4; i++) empty_v[i] = (srcq[i].size() == 0);
  endfunction

  function automatic bit src_empty();
    return (srcq[0].size() == 0) && (srcq[1].size() == 0) &&
           (srcq[2].size() == 0) && (srcq[3].size() == 0);
  endfunction

  // Source FIFO models: pop sampled mid-cycle, registered data appears after the edge.
  always @(negedge clk) begin
    if (!reset) p_s = 4'b0000;
    else        p_s = pops;
  end

  always @(posedge clk) begin
    #1;
    if (reset) begin
      for (int i = 0; i < 4; i++)
        if (p_s[i] && srcq[i].size() > 0) din[i] = srcq[i].pop_front();
      p_s = 4'b0000;
      upd_empty();
      if (af_mode == 1) almost_full = ($urandom_range(0, 9) < 3);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset) begin
      if (pops != 4'b0000) begin
        chk("pop_matches_grant", pops, 4'b0001 << grant_id);
        chk("pop_only_when_busy", busy, 1);
      end
      if (almost_full && busy) chk("stall_no_pop", pops, 0);
      if (!push) begin
        chk("data_zero_without_push", data_out, 0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_push", push, 0);
      end else begin
        e = exp_q.pop_front();
        chk("push_data", data_out, e[DATA_W-1:0]);
        chk("push_gid", grant_id, e[W-1:DATA_W]);
      end
    end
  end

  // Load source FIFOs and predict the output stream burst by burst.
  task automatic load(input int n[4], input bit seq);
    logic [DATA_W-1:0] w [4][$];
    logic [DATA_W-1:0] word;
    int g, k, idx;
    for (int v = 0; v < 4; v++)
      for (int j = 0; j < n[v]; j++) begin
        word = seq ? DATA_W'((v << 8) | (j + 1)) : DATA_W'($urandom_range(0, 4095));
        srcq[v].push_back(word);
        w[v].push_back(word);
      end
    upd_empty();
    while (1) begin
      g = -1;
      for (int c = 1; c <= 4; c++) begin
        idx = (model_last + c) % 4;
        if (g < 0 && w[idx].size() > 0) g = idx;
      end
      if (g < 0) break;
      k = (w[g].size() < BURST) ? w[g].size() : BURST;
      for (int j = 0; j < k; j++) exp_q.push_back({2'(g), w[g].pop_front()});
      model_last = g;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(src_empty() && exp_q.size() == 0 && !busy && !push) && n < 3000) begin
      @(posedge clk); #3;
      n++;
    end
    chk({name, "_drain_in_time"}, (n < 3000), 1);
  endtask

  initial begin
    int n, cnt;
    int nv[4];
    for (int i = 0; i < 4; i++) begin
      empty_v[i] = 1'b1;
      din[i]     = '0;
    end
    almost_full = 1'b0;
    p_s         = 4'b0000;
    reset       = 1'b0;

    // Reset held with all sources empty
    repeat (4) @(posedge clk);
    #2;
    chk("rst_pops", pops, 0);
    chk("rst_push", push, 0);
    chk("rst_data", data_out, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("idle_after_release_busy", busy, 0);
    chk("idle_after_release_pops", pops, 0);

    // All four channels loaded: VC0,VC1,VC2,VC3,VC0...
    load('{8, 8, 8, 8}, 1'b0);
    @(posedge clk); #2;
    chk("all_first_grant", grant_id, 0);
    drain("all_vc");

    // Only VC2 with 6 sequential words
    load('{0, 0, 6, 0}, 1'b1);
    chk("vc2_bubble_no_pop", pops, 0);
    for (int i = 0; i < BURST; i++) begin
      @(posedge clk); #2;
      chk("vc2_burst_pop", pops, 4'b0100);
    end
    @(posedge clk); #2;
    chk("vc2_rearb_idle", busy, 0);
    drain("vc2_only");

    // Stall mid-burst on VC1
    load('{0, 8, 0, 0}, 1'b0);
    n = 0; cnt = 0;
    while (cnt < 2 && n < 20) begin
      @(posedge clk); #2;
      n++;
      if (pop_1) cnt++;
    end
    chk("stall_two_pops_seen", cnt, 2);
    @(posedge clk); #2;
    almost_full = 1'b1;
    #1;
    chk("stall_pops", pops, 0);
    chk("stall_grant", grant_id, 1);
    chk("stall_busy", busy, 1);
    repeat (2) begin
      @(posedge clk); #3;
      chk("stall_hold_pops", pops, 0);
      chk("stall_hold_grant", grant_id, 1);
    end
    @(posedge clk); #2;
    almost_full = 1'b0;
    #1;
    cnt = pop_1 ? 1 : 0;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk); #3;
      n++;
      if (pop_1) cnt++;
    end
    chk("stall_pops_after_release", cnt, BURST - 2);
    drain("stall");

    // VC3 drains after one pop; next grant goes to VC0
    load('{0, 0, 1, 0}, 1'b0);
    drain("vc2_single");
    load('{3, 0, 0, 1}, 1'b0);
    @(posedge clk); #2;
    chk("drain_grant3", grant_id, 3);
    chk("drain_pop3", pops, 4'b1000);
    @(posedge clk); #2;
    chk("drain_exit_busy", busy, 1);
    chk("drain_exit_nopop", pops, 0);
    @(posedge clk); #2;
    chk("drain_idle", busy, 0);
    @(posedge clk); #2;
    chk("drain_next_grant0", grant_id, 0);
    chk("drain_next_pop0", pops, 4'b0001);
    drain("vc3_drain");

    // Randomized phases with random backpressure
    af_mode = 1;
    for (int ph = 0; ph < 8; ph++) begin
      for (int v = 0; v < 4; v++) nv[v] = $urandom_range(0, 10);
      load(nv, 1'b0);
      drain("random");
    end
    af_mode = 0;
    almost_full = 1'b0;
    @(posedge clk); #3;

    // Async reset in the middle of a VC1 burst
    load('{0, 8, 0, 0}, 1'b0);
    n = 0; cnt = 0;
    while (cnt < 2 && n < 20) begin
      @(posedge clk); #2;
      n++;
      if (pop_1) cnt++;
    end
    chk("arst_pop_pending", pop_1, 1);
    reset = 1'b0;
    #1;
    chk("arst_pops", pops, 0);
    chk("arst_push", push, 0);
    chk("arst_data", data_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_grant", grant_id, 0);
    for (int i = 0; i < 4; i++) srcq[i].delete();
    exp_q.delete();
    model_last = 3;
    upd_empty();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk); #2;
    chk("arst_no_push_after", push, 0);
    load('{5, 5, 0, 0}, 1'b0);
    @(posedge clk); #2;
    chk("arst_first_grant", grant_id, 0);
    chk("arst_first_busy", busy, 1);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/referee_rr_4.md
Name: referee_rr_4

Overview:
Round-robin scheduler that drains four virtual-channel source FIFOs (VC0..VC3) into one shared downstream FIFO of the transaction layer. It watches each source's empty flag and the destination's almost_full flag, drives the per-source pops and the destination push, and muxes the 12-bit word. Each grant lasts a bounded burst, so no channel starves the others.

Parameters:
DATA_W, 12, word width of every source and destination FIFO
BURST, 4, maximum pops per grant before re-arbitration (1..15)

Ports:
clk  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
empty_0..empty_3  input  1 each  source FIFO i holds no words
data_in_0..data_in_3  input  DATA_W each  registered read data of source FIFO i; valid the cycle after its pop
almost_full  input  1  destination FIFO can accept at most one more in-flight word
pop_0..pop_3  output  1 each  read strobe to source FIFO i
push  output  1  write strobe to destination FIFO
data_out  output  DATA_W  word for destination; 0 whenever push=0
grant_id  output  2  channel currently or last granted
busy  output  1  state==SERVE

Behaviour:
- Reset (reset=0, async): state=IDLE, pop_*=0, push=0, data_out=0, grant_id=0, burst count=0, last pointer=3 so VC0 has first priority, push pipeline flag cleared. Release is synchronous to the next clk edge.
- States: IDLE, SERVE. 2-bit state encoding.
- IDLE:
  - if almost_full=0 and any empty_i=0: grant = first non-empty channel scanning last+1, last+2, ... mod 4.
  - Load grant_id, clear count, go SERVE.
  - No pop is issued in IDLE: one bubble cycle per grant.
- SERVE, pop condition:
  - pop_g = busy & ~empty_g & ~almost_full, combinational from registered state and inputs.
  - Every other pop_i = 0. At most one pop is high in any cycle.
- SERVE, while almost_full=1: stall. No pop, grant held, count held.
- SERVE, exit to IDLE with last<=grant_id, after that cycle's pop if any, when either:
  - a pop occurs with count==BURST-1, or
  - empty_g=1 in SERVE (source drained).
- SERVE, otherwise: count increments on each pop.
- Datapath (1-cycle latency):
  - A pop in cycle N sets registered push=1 in cycle N+1, with gid_d = grant_id at N.
  - data_out in N+1 = data_in_{gid_d}, a mux from the registered gid_d.
  - Back-to-back pops give a continuous push stream.
- almost_full semantics: the threshold leaves room for the one in-flight word. A push in N+1 still occurs even if almost_full rises in N+1.
- Simultaneous events:
  - Burst end and source empty on the same cycle: a single transition to IDLE.
  - Channels becoming non-empty in IDLE are arbitrated on that same cycle.
- Reset mid-burst: any pending push is dropped, no partial word is emitted, and priority returns to VC0.
- count is 4 bits; BURST outside 1..15 is illegal and must be flagged by an elaboration-time check.

Decomposition:
- Shared package / include: state encodings (ST_IDLE, ST_SERVE), default DATA_W, NUM_VC=4.
- Sub-module rr_pick_4:
  - pure combinational round-robin picker.
  - inputs: req[3:0] = ~empty, last[1:0].
  - outputs: gnt_id[1:0], any.
  - reused by later egress referees.

Test Plan:
1. Reset held low 4 cycles, all FIFOs empty -> all pops/push/data_out=0, grant_id=0, busy=0. Release -> remains idle.
2. Only VC2 non-empty with 6 words (0x201..0x206), almost_full=0, BURST=4:
   - IDLE bubble, then pop_2 for 4 consecutive cycles; push 1 cycle later with data 0x201..0x204.
   - Return to IDLE, re-grant VC2, remaining 2 words follow.
3. All four VCs non-empty with 8 words each -> grant order VC0,VC1,VC2,VC3,VC0; exactly 4 pops per grant; one idle cycle between grants.
4. almost_full raised for 3 cycles mid-burst on VC1 after 2 pops -> pops stop the same cycle, grant_id stays 1, count holds. After release, exactly 2 more pops before re-arbitration. The in-flight push still completes.
5. VC3 goes empty after 1 pop of a burst -> SERVE exits next cycle, last=3, next grant is VC0 if VC0 is non-empty.
6. Async reset asserted mid-clock during a VC1 burst with a pop pending -> outputs 0 immediately without waiting for clk, no push next cycle, first grant after release is VC0.
